hc85_seq_cmp: RTL and testbench
===============================

// Module: hc85_seq_cmp
// PURPOSE
//  Parametrised sequential successor to the 4-bit HC85 magnitude comparator.
//  - Compares two multi-word operands streamed MS word first, WIDTH bits per beat.
//  - Final result uses 74HC85 cascade semantics on cas_in; output held until accepted.
//  - Sits where a chain of cascaded HC85 slices would otherwise be needed.
// PARAMETERS
//  WIDTH      4   bits per operand word (>=1)
//  MAX_WORDS  8   max beats per operand (>=1); the counter is $clog2(MAX_WORDS+1) bits
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          a_word/b_word/in_last valid
//  in_ready   out  1          block accepts a beat
//  a_word     in   WIDTH      operand A word, MS word first
//  b_word     in   WIDTH      operand B word, MS word first
//  in_last    in   1          beat is the LS word of the operand pair
//  cas_in     in   3          cascade {A>B,A=B,A<B}; sampled on the last beat
//  res_valid  out  1          result valid
//  res_ready  in   1          downstream accepts result
//  q          out  3          result {A>B,A=B,A<B}
//  words      out  CNT_W      beats consumed for this result
//  err        out  1          overrun: MAX_WORDS beats seen without in_last
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=0, res_valid=0, q=3'b000, words=0, err=0. Reset is honoured mid-operation; partial compares are dropped.
//  - Handshake: a beat transfers on the clk edge with in_valid&&in_ready. The result transfers on the edge with res_valid&&res_ready.
//  - in_ready=1 in IDLE and CMP, 0 in DONE. q/words/err are stable while res_valid=1.
//  - FSM:
//    - IDLE: first beat -> CMP, cnt=1, decision reg dec=NONE.
//    - IDLE with in_last on that beat -> DONE directly.
//    - CMP: each beat increments cnt; a beat with in_last -> DONE.
//    - CMP: cnt reaching MAX_WORDS without in_last -> DONE with err=1.
//    - DONE: res_valid=1; on res_ready -> IDLE. Zero-bubble back-to-back is not required.
//  - Decision: while dec=NONE, a_word>b_word sets dec=GT and a_word<b_word sets dec=LT (unsigned).
//    - Once set, dec is frozen; later beats are consumed and counted but ignored.
//  - Latency: q is registered; res_valid rises the cycle after the in_last beat is accepted.
//  - Result when dec=GT -> q=100; when dec=LT -> q=001.
//  - Result when dec=NONE (all words equal) -> 74HC85 cascade table on cas_in sampled with in_last:
//    - cas_in[1]=1 -> 010 (any other bits)
//    - 100 -> 100
//    - 001 -> 001
//    - 101 -> 000
//    - 000 -> 101
//  - Decision on the last beat itself is valid, e.g. a single-beat operand.
//  - err=1: q=000, words=MAX_WORDS. A beat with in_last exactly on beat MAX_WORDS is legal (err=0).
//  - words saturates at MAX_WORDS; no wrap-around.
// CONFIGURATION
//  SIGNED_CMP_EN defined:
//    - The first beat of each operand is compared as signed two's complement.
//    - Later beats are compared unsigned.
//    - The result is a signed compare of the full concatenated operand.
//  SIGNED_CMP_EN undefined: all beats are compared unsigned. No extra ports either way.
// TESTING
//  1 rst_n low mid-CMP (2 beats in) -> all outputs at reset values; the next operand compares cleanly.
//  2 WIDTH=4, beats A={1011,1010}, B={1011,1011}, cas_in=100 -> q=001, words=2.
//  3 beats A=B={1010,0101}:
//    - cas_in=100 -> q=100; 010 -> q=010; 101 -> q=000; 000 -> q=101.
//  4 res_ready held 0 for 5 cycles -> q/res_valid stable, in_ready=0.
//    - Then res_ready=1 -> res_valid falls the next cycle; in_ready=1.
//  5 MAX_WORDS=3, three equal beats with no in_last -> err=1, q=000, words=3.
//    - Same stream with in_last on beat 3 -> err=0.
//  6 single beat A=1000, B=0111:
//    - SIGNED_CMP_EN undefined -> q=100.
//    - SIGNED_CMP_EN defined -> q=001.

Source files
------------

// File: rtl/hc85_seq_cmp.sv
// Sequential multi-word magnitude comparator with 74HC85 cascade semantics.
// Optional macro SIGNED_CMP_EN: treat the first (MS) beat as signed two's complement.
module hc85_seq_cmp #(
  parameter  int WIDTH     = 4,
  parameter  int MAX_WORDS = 8,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic             in_last,
  input  logic [2:0]       cas_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       q,
  output logic [CNT_W-1:0] words,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  typedef enum logic [1:0] {D_NONE, D_GT, D_LT} dec_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state;
  dec_t             dec;
  logic [CNT_W-1:0] cnt;

  logic             beat;
  logic             first;
  logic             gt;
  logic             lt;
  dec_t             dec_cur;
  dec_t             dec_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // All-equal operands fall back to the HC85 cascade inputs.
  function automatic logic [2:0] cascade(input logic [2:0] cas);
    logic [2:0] r;
    if (cas[1]) begin
      r = 3'b010;
    end else begin
      case ({cas[2], cas[0]})
        2'b10:   r = 3'b100;
        2'b01:   r = 3'b001;
        2'b11:   r = 3'b000;
        default: r = 3'b101;
      endcase
    end
    return r;
  endfunction

  function automatic logic [2:0] result(input dec_t d, input logic [2:0] cas);
    logic [2:0] r;
    case (d)
      D_GT:    r = 3'b100;
      D_LT:    r = 3'b001;
      default: r = cascade(cas);
    endcase
    return r;
  endfunction

  always_comb begin
    beat    = in_valid && in_ready;
    first   = (state == IDLE);
    cnt_nxt = first ? ONE_CNT : cnt + ONE_CNT;
    dec_cur = first ? D_NONE : dec;
`ifdef SIGNED_CMP_EN
    // The MS beat carries the operand sign; lower beats are plain magnitude.
    if (first) begin
      gt = $signed(a_word) > $signed(b_word);
      lt = $signed(a_word) < $signed(b_word);
    end else begin
      gt = a_word > b_word;
      lt = a_word < b_word;
    end
`else
    gt = a_word > b_word;
    lt = a_word < b_word;
`endif
    dec_nxt = dec_cur;
    if (dec_cur == D_NONE) begin
      if (gt)      dec_nxt = D_GT;
      else if (lt) dec_nxt = D_LT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dec       <= D_NONE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      q         <= 3'b000;
      words     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE, CMP: begin
          in_ready <= 1'b1;
          if (beat) begin
            cnt   <= cnt_nxt;
            dec   <= dec_nxt;
            state <= CMP;
            if (in_last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
              q         <= result(dec_nxt, cas_in);
              words     <= cnt_nxt;
              err       <= 1'b0;
            end else if (cnt_nxt == MAX_CNT) begin
              // Overrun: the stream never terminated within MAX_WORDS beats.
              state     <= DONE;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
              q         <= 3'b000;
              words     <= MAX_CNT;
              err       <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc85_seq_cmp.sv
// Scoreboard bench for hc85_seq_cmp (WIDTH=4, MAX_WORDS=3).
module tb_hc85_seq_cmp;

  localparam int WIDTH     = 4;
  localparam int MAX_WORDS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a_word = '0;
  logic [3:0] b_word = '0;
  logic       in_last = 1'b0;
  logic [2:0] cas_in = '0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [2:0] q;
  logic [1:0] words;
  logic       err;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  hc85_seq_cmp #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_word(a_word), .b_word(b_word), .in_last(in_last), .cas_in(cas_in),
    .res_valid(res_valid), .res_ready(res_ready), .q(q), .words(words), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {q, words, err}.
  function automatic logic [5:0] model(input logic [11:0] a, input logic [11:0] b,
                                       input int n, input bit last, input logic [2:0] cas);
    logic [1:0] d;
    logic [3:0] aw, bw;
    logic [2:0] r;
    bit sg;
    d = 2'd0;
    if (!last && n >= MAX_WORDS) return {3'b000, 2'(MAX_WORDS), 1'b1};
    for (int i = 0; i < n; i++) begin
      aw = a[(n-1-i)*4 +: 4];
      bw = b[(n-1-i)*4 +: 4];
      sg = 1'b0;
`ifdef SIGNED_CMP_EN
      sg = (i == 0);
`endif
      if (d == 2'd0) begin
        if (sg) begin
          if ($signed(aw) > $signed(bw)) d = 2'd1;
          else if ($signed(aw) < $signed(bw)) d = 2'd2;
        end else begin
          if (aw > bw) d = 2'd1;
          else if (aw < bw) d = 2'd2;
        end
      end
    end
    if (d == 2'd1)      r = 3'b100;
    else if (d == 2'd2) r = 3'b001;
    else if (cas[1])    r = 3'b010;
    else begin
      case ({cas[2], cas[0]})
        2'b10:   r = 3'b100;
        2'b01:   r = 3'b001;
        2'b11:   r = 3'b000;
        default: r = 3'b101;
      endcase
    end
    return {r, 2'(n), 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("spurious_res", 32'(res_valid), 32'd0);
      else chk("res", 32'({q, words, err}), 32'(exp_q.pop_front()));
    end
  end

  task automatic beat(input logic [3:0] a, input logic [3:0] b, input bit last,
                      input logic [2:0] cas);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1; a_word = a; b_word = b; in_last = last; cas_in = cas;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_op(input logic [11:0] a, input logic [11:0] b, input int n,
                        input bit last, input logic [2:0] cas, input bit push);
    if (push) exp_q.push_back(model(a, b, n, last, cas));
    for (int i = 0; i < n; i++)
      beat(a[(n-1-i)*4 +: 4], b[(n-1-i)*4 +: 4], last && (i == n-1), cas);
    idle();
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_q"}, 32'(q), 32'd0);
    chk({tag, "_words"}, 32'(words), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  logic [11:0] ra, rb;
  int rn;

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("init");
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset in the middle of a compare, then a clean operand.
    run_op(12'h0BA, 12'h0BB, 2, 1'b0, 3'b100, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(12'h0BA, 12'h0BB, 2, 1'b1, 3'b100, 1'b1);
    wait_drain();

    // Equal operands: cascade table.
    run_op(12'h0A5, 12'h0A5, 2, 1'b1, 3'b100, 1'b1); wait_drain();
    run_op(12'h0A5, 12'h0A5, 2, 1'b1, 3'b010, 1'b1); wait_drain();
    run_op(12'h0A5, 12'h0A5, 2, 1'b1, 3'b101, 1'b1); wait_drain();
    run_op(12'h0A5, 12'h0A5, 2, 1'b1, 3'b000, 1'b1); wait_drain();
    run_op(12'h0A5, 12'h0A5, 2, 1'b1, 3'b001, 1'b1); wait_drain();
    run_op(12'h0A5, 12'h0A5, 2, 1'b1, 3'b111, 1'b1); wait_drain();

    // Decision frozen after the MS word.
    run_op(12'h280, 12'h17F, 3, 1'b1, 3'b001, 1'b1); wait_drain();

    // Overrun vs. legal last on beat MAX_WORDS.
    run_op(12'h333, 12'h333, 3, 1'b0, 3'b010, 1'b1); wait_drain();
    run_op(12'h333, 12'h333, 3, 1'b1, 3'b010, 1'b1); wait_drain();

    // Single beat with a sign-dependent outcome.
    run_op(12'h008, 12'h007, 1, 1'b1, 3'b000, 1'b1); wait_drain();

    // Back-pressure on the result.
    @(posedge clk); #1 res_ready = 1'b0;
    run_op(12'h0C6, 12'h0C6, 2, 1'b1, 3'b010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_q", 32'(q), 32'b010);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rel_res_valid", 32'(res_valid), 32'd0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_sb_empty", 32'(exp_q.size()), 32'd0);

    // Random operands, biased toward equal MS words.
    for (int t = 0; t < 10; t++) begin
      rn = $urandom_range(1, 3);
      ra = 12'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? ra : 12'($urandom);
      if (($urandom_range(0, 3) == 0) && rn > 1) rb[3:0] = 4'($urandom);
      run_op(ra, rb, rn, 1'b1, 3'($urandom), 1'b1);
      wait_drain();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
